// File: rtl/stopwatch_pkg.sv
// Shared state encoding and BCD limits for the stopwatch time counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // Seconds field limit (59) expressed as a binary value for the counter.
  localparam logic [6:0] SEC_LIMIT = 7'(int'(SEC_TENS_MAX) * 10 + int'(DIGIT_MAX));

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter that wraps to 00 after reaching a binary limit (<= 59).
module bcd_mod60_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [6:0] limit,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic [6:0] limit_tens;
  logic [6:0] limit_ones;
  logic       at_limit;

  // limit is tied to a constant at every instance, so this folds away.
  assign limit_tens = limit / 7'd10;
  assign limit_ones = limit % 7'd10;
  assign at_limit   = ({3'b000, tens} == limit_tens) && ({3'b000, ones} == limit_ones);
  assign carry      = inc && at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_limit) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == DIGIT_MAX) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch counter driven by edges of the divider tick level.
// Define STOPWATCH_TICK_SYNC_EN to insert a two-flop synchronizer on tick_in.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [6:0] MIN_LIMIT = 7'(MAX_MIN);

  state_t state;
  state_t state_next;
  logic   sampled;
  logic   tick_prev;
  logic   rise;
  logic   any_edge;
  logic   sec_inc;
  logic   sec_carry;
  logic   min_inc;
  logic   min_carry;

`ifdef STOPWATCH_TICK_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= tick_in;
      sync_q2 <= sync_q1;
    end
  end

  assign sampled = sync_q2;
`else
  assign sampled = tick_in;
`endif

  assign rise     = sampled & ~tick_prev;
  assign any_edge = sampled ^ tick_prev;

  // tick_prev tracks in every state, so leaving PAUSED/ADJUST never replays an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_prev <= 1'b0;
      state     <= ST_PAUSED;
    end else begin
      tick_prev <= sampled;
      state     <= state_next;
    end
  end

  // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_next = ST_RUN;
    if (adj) begin
      state_next = ST_ADJUST;
    end else if (pause) begin
      state_next = ST_PAUSED;
    end
  end

  // Edges are applied under the currently registered state.
  assign sec_inc = ((state == ST_RUN) && rise) || ((state == ST_ADJUST) && any_edge && sel);
  assign min_inc = ((state == ST_RUN) && sec_carry) || ((state == ST_ADJUST) && any_edge && !sel);

  bcd_mod60_counter u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .limit (SEC_LIMIT),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .limit (MIN_LIMIT),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= (state == ST_RUN) && sec_carry && min_carry;
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against an arithmetic MM:SS model.
module tb_stopwatch_time_counter;

  localparam int MAX_MIN = 59;
`ifdef STOPWATCH_TICK_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int M_RUN    = 0;
  localparam int M_PAUSED = 1;
  localparam int M_ADJ    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       pause = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, wrap;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;

  // Reference model state
  int m_min, m_sec, m_mode;
  bit m_wrap, m_prev, m_s1, m_s2, smp;

  stopwatch_time_counter #(.MAX_MIN(MAX_MIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .pause    (pause),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_min = 0; m_sec = 0; m_mode = M_PAUSED; m_wrap = 0;
      m_prev = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      smp = (LAT == 2) ? m_s2 : tick_in;
      m_wrap = 0;
      if (m_mode == M_RUN && smp && !m_prev) begin
        m_sec = m_sec + 1;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min = m_min + 1;
          if (m_min > MAX_MIN) begin
            m_min = 0;
            m_wrap = 1;
          end
        end
      end else if (m_mode == M_ADJ && smp != m_prev) begin
        if (sel) m_sec = (m_sec + 1) % 60;
        else     m_min = (m_min + 1) % (MAX_MIN + 1);
      end
      m_mode = adj ? M_ADJ : (pause ? M_PAUSED : M_RUN);
      m_prev = smp;
      m_s2 = m_s1;
      m_s1 = tick_in;
    end
  end

  function automatic int dut_digits();
    return {16'd0, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  function automatic int bcd(int mm, int ss);
    return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    check("digits", dut_digits(), bcd(m_min, m_sec));
    check("running", int'(running), int'(m_mode == M_RUN));
    check("wrap", int'(wrap), int'(m_wrap));
    if (wrap) wrap_cnt++;
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = ~tick_in;
      repeat (4) step();
    end
  endtask

  task automatic set_in(input bit a, input bit p, input bit s);
    adj = a; pause = p; sel = s;
    step(); step();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_in = 1'b0; adj = 1'b0; pause = 1'b0; sel = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step();
  endtask

  initial begin
    int lat_seen;
    int old_ones;

    // Reset state
    step(); step();
    check("rst_digits", dut_digits(), 0);
    check("rst_running", int'(running), 0);
    check("rst_wrap", int'(wrap), 0);
    rst = 1'b0;
    step();
    check("run_after_rst", int'(running), 1);

    // Five seconds in RUN
    toggle(10);
    check("five_sec", dut_digits(), 16'h0005);
    check("five_nowrap", wrap_cnt, 0);

    // Preload 59:58 in ADJUST, then roll over in RUN
    set_in(1, 0, 0);
    toggle(59);
    set_in(1, 0, 1);
    toggle(53);
    check("preload", dut_digits(), 16'h5958);
    set_in(0, 0, 0);
    toggle(1);
    check("to_5959", dut_digits(), 16'h5959);
    toggle(1);
    toggle(1);
    check("wrapped", dut_digits(), 16'h0000);
    check("wrap_once", wrap_cnt, 1);
    toggle(1);

    // Pause holds
    toggle(20);
    check("at_0010", dut_digits(), 16'h0010);
    set_in(0, 1, 0);
    toggle(6);
    check("paused_hold", dut_digits(), 16'h0010);
    check("paused_state", int'(running), 0);
    set_in(0, 0, 0);
    toggle(2);
    check("resume", dut_digits(), 16'h0011);

    // Adjust seconds wraps without carry, then minutes
    set_in(1, 0, 1);
    toggle(47);
    check("adj_0058", dut_digits(), 16'h0058);
    toggle(1); check("adj_0059", dut_digits(), 16'h0059);
    toggle(1); check("adj_0000", dut_digits(), 16'h0000);
    toggle(1); check("adj_0001", dut_digits(), 16'h0001);
    toggle(1); check("adj_0002", dut_digits(), 16'h0002);
    set_in(1, 0, 0);
    toggle(2);
    check("adj_min", dut_digits(), 16'h0202);
    check("adj_nowrap", wrap_cnt, 1);

    // Reset while running at 12:34
    do_reset();
    set_in(1, 0, 0);
    toggle(12);
    set_in(1, 0, 1);
    toggle(34);
    set_in(0, 0, 0);
    check("at_1234", dut_digits(), 16'h1234);
    check("run_1234", int'(running), 1);
    rst = 1'b1;
    tick_in = 1'($urandom_range(0, 1));
    step();
    rst = 1'b0;
    check("rst_mid_digits", dut_digits(), 0);
    check("rst_mid_paused", int'(running), 0);
    step();

    // Tick latency from first high sample
    do_reset();
    repeat (4) step();
    tick_in = 1'b1;
    old_ones = int'(sec_ones);
    lat_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (int'(sec_ones) != old_ones) begin
        lat_seen = k;
        break;
      end
    end
    check("latency", lat_seen, LAT + 1);
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)   tick_in = ~tick_in;
      if ($urandom_range(0, 39) == 0)  adj = ~adj;
      if ($urandom_range(0, 29) == 0)  pause = ~pause;
      if ($urandom_range(0, 19) == 0)  sel = ~sel;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
